rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Shares the single-port sprite ROM between two renderers: the square renderer (SQ) and the bsprite renderer (BS).
- Replaces the static address mux with a registered, handshaked arbiter that issues one ROM read per cycle.
- Routes each read's data back to the requester that issued it.
- Priority depends on frame phase: SQ is preferred until its first SWITCH_ROWS*ROW_PIX pixels have been fetched, then BS is preferred. A starvation guard applies in both phases.

Parameters:
- ADDR_W, 16, ROM address width.
- DATA_W, 12, ROM data width (RGB444).
- ROW_PIX, 200, pixels per sprite row.
- SWITCH_ROWS, 3, SQ rows fetched before priority flips.
- ROM_LAT, 1, ROM read latency in cycles from rom_en/rom_addr sampled to rom_data valid (1..4).
- STARVE_MAX, 4, consecutive lost cycles after which the losing requester is forced to win.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- frame_start, in, 1: one-cycle pulse at the start of each frame.
- sq_req, in, 1: SQ read request. Held, with sq_addr stable, until accepted.
- sq_addr, in, ADDR_W: SQ ROM address.
- sq_gnt, out, 1: combinational grant to SQ. Accept = sq_req && sq_gnt at a rising edge.
- sq_rvalid, out, 1: SQ read data valid, one cycle per accepted read.
- sq_rdata, out, DATA_W: SQ read data.
- bs_req, bs_addr, bs_gnt, bs_rvalid, bs_rdata: same as the SQ ports, for BS.
- rom_en, out, 1: ROM read enable.
- rom_addr, out, ADDR_W: ROM address.
- rom_data, in, DATA_W: ROM read data.
- phase_bs, out, 1: 1 when BS has priority (debug/status).

Behaviour:
- Reset values: all outputs 0; phase = PH_SQ; sq_cnt = 0; starvation counters = 0; in-flight pipeline cleared.
- Phase FSM, two states:
  - PH_SQ → PH_BS on the edge where sq_cnt becomes > SWITCH_ROWS*ROW_PIX (i.e. at the 601st SQ accept by default).
  - Any state → PH_SQ on frame_start.
  - No other transitions.
- sq_cnt:
  - 16-bit; +1 per SQ accept; saturates at 0xFFFF.
  - Cleared by frame_start.
  - frame_start coincident with an SQ accept: the read proceeds normally, but sq_cnt = 0 afterwards (the accept is not counted).
- Grant, combinational:
  - At most one grant per cycle; a grant is asserted only to a requester whose req is high.
  - Single requester wins.
  - Both requesting: the forced requester wins if it is forced; otherwise the phase-preferred one wins (SQ in PH_SQ, BS in PH_BS).
- Starvation counters, one per requester, 3 bits:
  - +1 each cycle the requester has req high and is not granted.
  - Cleared on its accept, or when its req is low.
  - Requester is forced when counter >= STARVE_MAX-1.
  - Both forced cannot occur, since exactly one requester wins each contended cycle.
- Issue:
  - On an accept at edge E0: rom_addr <= winning addr and rom_en <= 1, both registered.
  - A tag (owner) enters a shift pipe of depth ROM_LAT+1.
  - rom_en = 0 on non-accept cycles; rom_addr holds its last value.
- Return:
  - At edge E0+1+ROM_LAT the tagged owner's rdata register <= rom_data, and its rvalid = 1 for exactly one cycle.
  - The other requester's rvalid = 0; its rdata holds.
  - Total latency from accept edge to rvalid high is ROM_LAT+1 cycles.
  - Back-to-back accepts produce back-to-back rvalids in accept order.
- Throughput: one accept per cycle sustained, with no bubbles.
- rst asserted mid-operation: in-flight reads are discarded, no rvalid is produced for them, and all state returns to reset values immediately (asynchronous).
- frame_start does not flush in-flight reads.

Test Plan:
- Reset, then SQ-only requests to addr 0x0000..0x0009 on consecutive cycles → sq_gnt=1 every cycle; rom_addr follows one cycle later; sq_rvalid for 10 consecutive cycles starting 2 cycles after the first accept (ROM_LAT=1); bs_rvalid=0 throughout.
- Both requesting continuously from frame start → SQ wins 3 cycles, then BS is forced on the 4th; pattern SQ,SQ,SQ,BS repeats; phase_bs=0.
- SQ accepts reach 601 (sq_cnt > 600) → phase_bs=1 on the next cycle; with both requesting, BS wins 3 cycles, then SQ is forced on the 4th.
- frame_start pulse while in PH_BS, coincident with an SQ accept → phase_bs=0 next cycle; sq_cnt=0; that read still returns sq_rvalid after 2 cycles.
- Alternating SQ/BS accepts, ROM model returning data=addr, with ROM_LAT=3 → each rvalid arrives 4 cycles after its accept, to the correct owner, with matching data, in order.
- rst asserted for 1 cycle with 2 reads in flight → no rvalid afterwards; all outputs 0; phase_bs=0; normal operation resumes after rst is released.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// rom_port_arbiter: handshaked two-port arbiter that shares a single-port ROM
// between the square (SQ) and bsprite (BS) renderers. The priority depends on
// the frame phase, a starvation guard applies, and each read returns to the
// requester that issued it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 12,
  parameter int ROW_PIX     = 200,
  parameter int SWITCH_ROWS = 3,
  parameter int ROM_LAT     = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              sq_req,
  input  logic [ADDR_W-1:0] sq_addr,
  output logic              sq_gnt,
  output logic              sq_rvalid,
  output logic [DATA_W-1:0] sq_rdata,
  input  logic              bs_req,
  input  logic [ADDR_W-1:0] bs_addr,
  output logic              bs_gnt,
  output logic              bs_rvalid,
  output logic [DATA_W-1:0] bs_rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              phase_bs
);

  typedef enum logic [0:0] {
    PH_SQ = 1'b0,
    PH_BS = 1'b1
  } phase_t;

  localparam logic [15:0] SWITCH_CNT = 16'(SWITCH_ROWS * ROW_PIX);
  localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX - 1);
  localparam int          PIPE_D     = ROM_LAT + 1;

  phase_t              phase_q, phase_d;
  logic [15:0]         sq_cnt_q, sq_cnt_d;
  logic [2:0]          sq_starve_q, sq_starve_d;
  logic [2:0]          bs_starve_q, bs_starve_d;
  logic [PIPE_D-1:0]   pipe_v_q;
  logic [PIPE_D-1:0]   pipe_bs_q;
  logic                rom_en_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                sq_rvalid_q, bs_rvalid_q;
  logic [DATA_W-1:0]   sq_rdata_q, bs_rdata_q;

  logic sq_forced, bs_forced;
  logic sq_win, bs_win, any_win;
  logic ret_v, ret_bs;

  // A forced requester beats phase preference; both forced cannot happen
  // because a contended cycle always resets the winner's counter.
  always_comb begin
    sq_forced = (sq_starve_q >= STARVE_LIM);
    bs_forced = (bs_starve_q >= STARVE_LIM);
    sq_win    = 1'b0;
    bs_win    = 1'b0;
    if (sq_req && bs_req) begin
      if (sq_forced)               sq_win = 1'b1;
      else if (bs_forced)          bs_win = 1'b1;
      else if (phase_q == PH_BS)   bs_win = 1'b1;
      else                         sq_win = 1'b1;
    end else begin
      sq_win = sq_req;
      bs_win = bs_req;
    end
    any_win = sq_win | bs_win;
  end

  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (frame_start)
      sq_cnt_d = 16'd0;
    else if (sq_win && (sq_cnt_q != 16'hFFFF))
      sq_cnt_d = sq_cnt_q + 16'd1;

    phase_d = phase_q;
    if (frame_start)
      phase_d = PH_SQ;
    else if ((phase_q == PH_SQ) && (sq_cnt_d > SWITCH_CNT))
      phase_d = PH_BS;

    if (!sq_req || sq_win)          sq_starve_d = 3'd0;
    else if (sq_starve_q != 3'd7)   sq_starve_d = sq_starve_q + 3'd1;
    else                            sq_starve_d = sq_starve_q;

    if (!bs_req || bs_win)          bs_starve_d = 3'd0;
    else if (bs_starve_q != 3'd7)   bs_starve_d = bs_starve_q + 3'd1;
    else                            bs_starve_d = bs_starve_q;
  end

  // The tag at the pipe tail lines up with rom_data being valid for that read.
  assign ret_v  = pipe_v_q[ROM_LAT];
  assign ret_bs = pipe_bs_q[ROM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH_SQ;
      sq_cnt_q    <= 16'd0;
      sq_starve_q <= 3'd0;
      bs_starve_q <= 3'd0;
      pipe_v_q    <= '0;
      pipe_bs_q   <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      sq_rvalid_q <= 1'b0;
      bs_rvalid_q <= 1'b0;
      sq_rdata_q  <= '0;
      bs_rdata_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      sq_cnt_q    <= sq_cnt_d;
      sq_starve_q <= sq_starve_d;
      bs_starve_q <= bs_starve_d;
      pipe_v_q    <= {pipe_v_q[PIPE_D-2:0], any_win};
      pipe_bs_q   <= {pipe_bs_q[PIPE_D-2:0], bs_win};
      rom_en_q    <= any_win;
      if (any_win)
        rom_addr_q <= bs_win ? bs_addr : sq_addr;
      sq_rvalid_q <= ret_v && !ret_bs;
      bs_rvalid_q <= ret_v && ret_bs;
      if (ret_v && !ret_bs)
        sq_rdata_q <= rom_data;
      if (ret_v && ret_bs)
        bs_rdata_q <= rom_data;
    end
  end

  assign sq_gnt    = sq_win;
  assign bs_gnt    = bs_win;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign sq_rvalid = sq_rvalid_q;
  assign bs_rvalid = bs_rvalid_q;
  assign sq_rdata  = sq_rdata_q;
  assign bs_rdata  = bs_rdata_q;
  assign phase_bs  = (phase_q == PH_BS);

endmodule

`default_nettype wire
